fpcvt_pipe: RTL

- Parametrised, pipelined successor to the 12-bit combinational two's-complement to floating-point converter.
- Converts a DW-bit signed integer to sign / EW-bit exponent / FW-bit fraction, value = F * 2^E.
- Offers a per-transaction round-or-truncate mode and reports saturation.
- Three register stages with a valid/ready handshake on each side, so it can sit between a sample source and a downstream consumer that applies backpressure.

---
 rtl/fpcvt_pkg.sv | 37 +++
 rtl/fpcvt_lzc.sv | 21 ++
 rtl/fpcvt_pipe.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fpcvt_pkg.sv
// Shared widths, saturation constants and per-stage payload types for the
// pipelined integer to floating-point converter.
package fpcvt_pkg;

  localparam int unsigned EW_DEF = 3;
  localparam int unsigned FW_DEF = 4;
  localparam int unsigned DW_DEF = (1 << EW_DEF) + FW_DEF;
  localparam int unsigned LZW    = $clog2(DW_DEF + 1);
  localparam int unsigned IW     = $clog2(DW_DEF);

  localparam logic [EW_DEF-1:0] E_MAX = '1;
  localparam logic [FW_DEF-1:0] F_MAX = '1;

  typedef struct packed {
    logic              s;
    logic [DW_DEF-1:0] mag;
    logic              trunc;
    logic              sat;
  } s1_t;

  typedef struct packed {
    logic              s;
    logic [EW_DEF-1:0] e;
    logic [FW_DEF-1:0] f;
    logic              r;
    logic              trunc;
    logic              sat;
  } s2_t;

  typedef struct packed {
    logic              s;
    logic [EW_DEF-1:0] e;
    logic [FW_DEF-1:0] f;
    logic              sat;
  } s3_t;

endpackage

// File: rtl/fpcvt_lzc.sv
// Combinational leading-zero counter; an all-zero input reports DW.
module fpcvt_lzc #(
  parameter int unsigned DW = 12
) (
  input  logic [DW-1:0]            mag_i,
  output logic [$clog2(DW+1)-1:0]  lz_o
);

  localparam int unsigned LzW = $clog2(DW + 1);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    lz_o = LzW'(DW);
    for (int i = 0; i < DW; i++) begin
      if (mag_i[i]) begin
        lz_o = LzW'(DW - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fpcvt_pipe.sv
// Three-stage valid/ready pipeline converting a two's-complement sample to
// sign / exponent / fraction with optional rounding and saturation flag.
module fpcvt_pipe
  import fpcvt_pkg::*;
#(
  parameter int unsigned EW = EW_DEF,
  parameter int unsigned FW = FW_DEF,
  parameter int unsigned DW = (1 << EW) + FW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_trunc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_s,
  output logic [EW-1:0] out_e,
  output logic [FW-1:0] out_f,
  output logic          out_sat
);

  if (EW != EW_DEF || FW != FW_DEF || DW != (1 << EW) + FW) begin : g_param_check
    $error("fpcvt_pipe: EW/FW must match fpcvt_pkg and DW must equal (1<<EW)+FW");
  end

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;
  logic v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic ld1, ld2, ld3;

  logic [LZW-1:0]    lz;
  logic [IW-1:0]     top_idx;
  logic [DW_DEF-1:0] mag_raw;
  logic              is_min;
  logic [FW_DEF:0]   f_inc;

  // Each stage loads when empty or when its occupant moves on this cycle.
  assign ld3      = !v3_q || out_ready;
  assign ld2      = !v2_q || ld3;
  assign ld1      = !v1_q || ld2;
  assign in_ready = ld1;

  assign v1_d = ld1 ? in_valid : v1_q;
  assign v2_d = ld2 ? v1_q     : v2_q;
  assign v3_d = ld3 ? v2_q     : v3_q;

  // S1: sign and magnitude; the most negative value has no positive twin.
  always_comb begin
    mag_raw = in_data[DW-1] ? -in_data : in_data;
    is_min  = (in_data == {1'b1, {(DW-1){1'b0}}});
    s1_d    = s1_q;
    if (ld1 && in_valid) begin
      s1_d.s     = in_data[DW-1];
      s1_d.mag   = is_min ? {1'b0, {(DW-1){1'b1}}} : mag_raw;
      s1_d.trunc = in_trunc;
      s1_d.sat   = is_min;
    end
  end

  fpcvt_lzc #(
    .DW (DW_DEF)
  ) u_lzc (
    .mag_i (s1_q.mag),
    .lz_o  (lz)
  );

  // S2: normalise around the leading one; small values stay denormal at E=0.
  always_comb begin
    top_idx = IW'(DW_DEF - 1) - IW'(lz);
    s2_d    = s2_q;
    if (ld2 && v1_q) begin
      s2_d.s     = s1_q.s;
      s2_d.trunc = s1_q.trunc;
      s2_d.sat   = s1_q.sat;
      if (lz >= LZW'(1 << EW_DEF)) begin
        s2_d.e = '0;
        s2_d.f = s1_q.mag[FW_DEF-1:0];
        s2_d.r = 1'b0;
      end else begin
        s2_d.e = EW_DEF'((1 << EW_DEF) - lz);
        s2_d.f = s1_q.mag[top_idx -: FW_DEF];
        s2_d.r = s1_q.mag[top_idx - IW'(FW_DEF)];
      end
    end
  end

  // S3: round half up, renormalise on fraction carry, clamp on exponent carry.
  always_comb begin
    f_inc = {1'b0, s2_q.f} + (FW_DEF + 1)'(s2_q.r && !s2_q.trunc);
    s3_d  = s3_q;
    if (ld3 && v2_q) begin
      s3_d.s   = s2_q.s;
      s3_d.e   = s2_q.e;
      s3_d.f   = f_inc[FW_DEF-1:0];
      s3_d.sat = s2_q.sat;
      if (f_inc[FW_DEF]) begin
        if (s2_q.e == E_MAX) begin
          s3_d.e   = E_MAX;
          s3_d.f   = F_MAX;
          s3_d.sat = 1'b1;
        end else begin
          s3_d.e = s2_q.e + 1'b1;
          s3_d.f = {1'b1, {(FW_DEF-1){1'b0}}};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign out_valid = v3_q;
  assign out_s     = s3_q.s;
  assign out_e     = s3_q.e;
  assign out_f     = s3_q.f;
  assign out_sat   = s3_q.sat;

endmodule
